riscv_aes_result_writer: RTL and testbench

- Engine-side counterpart of the AES register file.
- Turns the register file's start level into a single-cycle start pulse for the AES datapath, then waits for completion and captures the 128-bit result.
- Writes the result back into the register file's data bank as four 32-bit words, through the same write port the core uses, under a request/grant arbitration with the core.

---
 rtl/riscv_aes_result_writer.sv | 124 ++++++++++++
 tb/tb_riscv_aes_result_writer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_aes_result_writer.sv
// riscv_aes_result_writer: start-pulse generator, AES result capture and 4-word register-file writeback.
// Optional WAIT watchdog is enabled by defining RISCV_AES_TIMEOUT_EN.
module riscv_aes_result_writer #(
   parameter int         ADDR_WIDTH     = 2,
   parameter int         DATA_WIDTH     = 32,
   parameter logic [1:0] WB_SEL         = 2'd0,
   parameter int         TIMEOUT_CYCLES = 1024
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    test_en_i,
   input  logic                    start_lvl_i,
   output logic                    aes_start_o,
   input  logic                    aes_done_i,
   input  logic [4*DATA_WIDTH-1:0] aes_result_i,
   output logic                    wb_req_o,
   input  logic                    wb_gnt_i,
   output logic [ADDR_WIDTH-1:0]   waddr_o,
   output logic [DATA_WIDTH-1:0]   wdata_o,
   output logic                    wen_o,
   output logic [1:0]              instruction_sel_o,
   output logic                    busy_o,
   output logic                    done_o,
   output logic                    err_o
);
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] START = 2'd1;
   localparam logic [1:0] WAIT  = 2'd2;
   localparam logic [1:0] WB    = 2'd3;
   localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(3);

   logic [1:0]              state_q, state_d;
   logic                    start_q, start_d;
   logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
   logic [4*DATA_WIDTH-1:0] res_q, res_d;
   logic                    done_q, done_d;
   logic                    err_q, err_d;
   logic                    start_edge;
   logic                    timeout;

`ifdef RISCV_AES_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
   logic [CW-1:0] cnt_q, cnt_d;
   // Counter is held at zero outside WAIT, so it restarts on every WAIT entry.
   always_comb cnt_d = (state_q == WAIT) ? cnt_q + CW'(1) : '0;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   assign timeout = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT_CYCLES > 0);
   assign timeout = 1'b0;
`endif

   assign start_d    = start_lvl_i;
   assign start_edge = start_lvl_i & ~start_q & ~test_en_i;

   assign instruction_sel_o = WB_SEL;
   assign aes_start_o       = (state_q == START) & ~test_en_i;
   assign busy_o            = (state_q != IDLE);
   assign wb_req_o          = (state_q == WB);
   assign wen_o             = (state_q == WB) & wb_gnt_i & ~test_en_i;
   assign waddr_o           = (state_q == WB) ? idx_q : '0;
   assign wdata_o           = (state_q == WB) ? res_q[idx_q*DATA_WIDTH +: DATA_WIDTH] : '0;
   assign done_o            = done_q & ~test_en_i;
   assign err_o             = err_q;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      res_d   = res_q;
      done_d  = done_q;
      err_d   = err_q;
      case (state_q)
         IDLE:
            if (start_edge) begin
               state_d = START;
               done_d  = 1'b0;
               err_d   = 1'b0;
            end
         START: state_d = WAIT;
         WAIT:
            if (aes_done_i) begin
               res_d   = aes_result_i;
               idx_d   = '0;
               state_d = WB;
            end else if (timeout) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end
         default:
            if (wen_o) begin
               idx_d = idx_q + ADDR_WIDTH'(1);
               if (idx_q == LAST_IDX) begin
                  idx_d   = '0;
                  done_d  = 1'b1;
                  state_d = IDLE;
               end
            end
      endcase
      if (test_en_i) begin
         state_d = IDLE;
         done_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q <= IDLE;
         start_q <= 1'b0;
         idx_q   <= '0;
         res_q   <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         start_q <= start_d;
         idx_q   <= idx_d;
         res_q   <= res_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
endmodule

// File: tb/tb_riscv_aes_result_writer.sv
// tb_riscv_aes_result_writer: directed-vector bench for riscv_aes_result_writer.
module tb_riscv_aes_result_writer;
   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         test_en = 1'b0;
   logic         start_lvl = 1'b0;
   logic         aes_done = 1'b0;
   logic [127:0] aes_result = '0;
   logic         wb_gnt = 1'b0;
   logic         aes_start, wb_req, wen, busy, done, err;
   logic [1:0]   waddr, isel;
   logic [31:0]  wdata;
   int           n_checks = 0;
   int           n_fail = 0;

   localparam logic [127:0] R1 = 128'h33333333_22222222_11111111_00000000;
   localparam logic [127:0] R2 = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
   localparam logic [127:0] R3 = 128'h76543210_FEDCBA98_0BADF00D_DEADBEEF;
   localparam logic [127:0] R4 = 128'h99999999_88888888_77777777_66666666;
   logic [31:0] w1 [4] = '{32'h00000000, 32'h11111111, 32'h22222222, 32'h33333333};
   logic [31:0] w2 [4] = '{32'hAAAAAAAA, 32'hBBBBBBBB, 32'hCCCCCCCC, 32'hDDDDDDDD};
   logic [31:0] w3 [4] = '{32'hDEADBEEF, 32'h0BADF00D, 32'hFEDCBA98, 32'h76543210};

   riscv_aes_result_writer #(.TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .rst_n(rst_n), .test_en_i(test_en), .start_lvl_i(start_lvl),
      .aes_start_o(aes_start), .aes_done_i(aes_done), .aes_result_i(aes_result),
      .wb_req_o(wb_req), .wb_gnt_i(wb_gnt), .waddr_o(waddr), .wdata_o(wdata),
      .wen_o(wen), .instruction_sel_o(isel), .busy_o(busy), .done_o(done), .err_o(err)
   );

   initial forever #5 clk = ~clk;

   task automatic next();
      @(negedge clk);
   endtask

   // Leaves the DUT in its first WAIT cycle, at the negedge, inputs free to drive.
   task automatic kick();
      next(); start_lvl = 1'b0;
      next(); start_lvl = 1'b1;
      next();
      next();
   endtask

   task automatic test_reset();
      next(); #1;
      n_checks++;
      if ({aes_start, wb_req, wen, waddr, wdata, busy, done, err} !== '0) begin
         n_fail++; $display("FAIL reset_outputs: got %h required 0", {aes_start, wb_req, wen, waddr, wdata, busy, done, err});
      end
      n_checks++;
      if (isel !== 2'd0) begin n_fail++; $display("FAIL reset_isel: got %0d required 0", isel); end
      next(); rst_n = 1'b1;
   endtask

   task automatic test_start();
      next(); start_lvl = 1'b1; #1;
      n_checks++;
      if ({aes_start, busy} !== 2'b00) begin n_fail++; $display("FAIL start_edge_cycle: got %b required 00", {aes_start, busy}); end
      next(); #1;
      n_checks++;
      if ({aes_start, busy} !== 2'b11) begin n_fail++; $display("FAIL start_pulse: got %b required 11", {aes_start, busy}); end
      for (int i = 0; i < 3; i++) begin
         next(); #1;
         n_checks++;
         if ({aes_start, busy} !== 2'b01) begin n_fail++; $display("FAIL start_single: cycle %0d got %b required 01", i, {aes_start, busy}); end
      end
   endtask

   task automatic test_writeback();
      next(); aes_done = 1'b1; aes_result = R1; #1;
      n_checks++;
      if ({wen, wb_req} !== 2'b00) begin n_fail++; $display("FAIL wb_wait_idle: got %b required 00", {wen, wb_req}); end
      next(); aes_done = 1'b0; wb_gnt = 1'b1;
      for (int k = 0; k < 4; k++) begin
         if (k > 0) next();
         #1;
         n_checks++;
         if ({wen, wb_req, waddr, wdata, isel} !== {2'b11, 2'(k), w1[k], 2'd0}) begin
            n_fail++; $display("FAIL wb_word%0d: got wen=%b req=%b a=%0d d=%h sel=%0d required 1 1 %0d %h 0", k, wen, wb_req, waddr, wdata, isel, k, w1[k]);
         end
      end
      next(); wb_gnt = 1'b0; #1;
      n_checks++;
      if ({done, busy, wen, wb_req} !== 4'b1000) begin n_fail++; $display("FAIL wb_done: got %b required 1000", {done, busy, wen, wb_req}); end
   endtask

   task automatic test_gnt_toggle();
      int writes = 0;
      kick(); aes_done = 1'b1; aes_result = R2;
      next(); aes_done = 1'b0;
      for (int c = 0; c < 20; c++) begin
         wb_gnt = (c % 2 == 0); #1;
         n_checks++;
         if ({wb_req, wen} !== {1'b1, wb_gnt}) begin n_fail++; $display("FAIL tog_req_wen: cycle %0d got %b required %b", c, {wb_req, wen}, {1'b1, wb_gnt}); end
         if (wen) begin
            n_checks++;
            if ({waddr, wdata} !== {2'(writes), w2[writes]}) begin
               n_fail++; $display("FAIL tog_word: got a=%0d d=%h required a=%0d d=%h", waddr, wdata, writes, w2[writes]);
            end
            writes++;
         end
         if (writes == 4) break;
         next();
      end
      n_checks++;
      if (writes !== 4) begin n_fail++; $display("FAIL tog_count: got %0d writes required 4", writes); end
      next(); wb_gnt = 1'b0; #1;
      n_checks++;
      if ({done, busy, wen} !== 3'b100) begin n_fail++; $display("FAIL tog_done: got %b required 100", {done, busy, wen}); end
   endtask

   task automatic test_no_requeue();
      kick(); start_lvl = 1'b0;
      next(); start_lvl = 1'b1; #1;
      next(); #1;
      n_checks++;
      if ({aes_start, busy} !== 2'b01) begin n_fail++; $display("FAIL rq_wait_edge: got %b required 01", {aes_start, busy}); end
      aes_done = 1'b1; aes_result = R3;
      next(); aes_done = 1'b1; aes_result = R4; start_lvl = 1'b0; wb_gnt = 1'b0; #1;
      n_checks++;
      if ({wen, wb_req} !== 2'b01) begin n_fail++; $display("FAIL rq_wb_hold: got %b required 01", {wen, wb_req}); end
      next(); aes_done = 1'b0; start_lvl = 1'b1; wb_gnt = 1'b1;
      for (int k = 0; k < 4; k++) begin
         if (k > 0) next();
         #1;
         n_checks++;
         if ({aes_start, wen, waddr, wdata} !== {2'b01, 2'(k), w3[k]}) begin
            n_fail++; $display("FAIL rq_word%0d: got st=%b wen=%b a=%0d d=%h required 0 1 %0d %h", k, aes_start, wen, waddr, wdata, k, w3[k]);
         end
      end
      next(); wb_gnt = 1'b0; #1;
      n_checks++;
      if ({done, aes_start, busy} !== 3'b100) begin n_fail++; $display("FAIL rq_done: got %b required 100", {done, aes_start, busy}); end
      next(); start_lvl = 1'b0;
      next(); start_lvl = 1'b1; #1;
      next(); #1;
      n_checks++;
      if ({done, aes_start} !== 2'b01) begin n_fail++; $display("FAIL rq_restart: got %b required 01", {done, aes_start}); end
      next();
   endtask

   task automatic test_reset_mid();
      aes_done = 1'b1; aes_result = R2;
      next(); aes_done = 1'b0; wb_gnt = 1'b1;
      next();
      next(); #1;
      rst_n = 1'b0; #1;
      n_checks++;
      if ({aes_start, wb_req, wen, waddr, wdata, busy, done, err} !== '0) begin
         n_fail++; $display("FAIL mid_reset_outputs: got %h required 0", {aes_start, wb_req, wen, waddr, wdata, busy, done, err});
      end
      next(); rst_n = 1'b1; wb_gnt = 1'b0; #1;
      n_checks++;
      if ({busy, done} !== 2'b00) begin n_fail++; $display("FAIL mid_release: got %b required 00", {busy, done}); end
      kick(); aes_done = 1'b1; aes_result = R1;
      next(); aes_done = 1'b0; wb_gnt = 1'b1;
      for (int k = 0; k < 4; k++) begin
         if (k > 0) next();
         #1;
         n_checks++;
         if ({wen, waddr, wdata} !== {1'b1, 2'(k), w1[k]}) begin
            n_fail++; $display("FAIL mid_word%0d: got wen=%b a=%0d d=%h required 1 %0d %h", k, wen, waddr, wdata, k, w1[k]);
         end
      end
      next(); wb_gnt = 1'b0; #1;
      n_checks++;
      if ({done, busy} !== 2'b10) begin n_fail++; $display("FAIL mid_done: got %b required 10", {done, busy}); end
   endtask

   task automatic test_test_en();
      next(); test_en = 1'b1; #1;
      n_checks++;
      if (done !== 1'b0) begin n_fail++; $display("FAIL ten_done_mask: got %b required 0", done); end
      next(); test_en = 1'b0; #1;
      n_checks++;
      if (done !== 1'b0) begin n_fail++; $display("FAIL ten_done_clear: got %b required 0", done); end
      kick(); aes_done = 1'b1; aes_result = R2;
      next(); aes_done = 1'b0; wb_gnt = 1'b1; test_en = 1'b1; #1;
      n_checks++;
      if ({wen, aes_start} !== 2'b00) begin n_fail++; $display("FAIL ten_wen: got %b required 00", {wen, aes_start}); end
      next(); test_en = 1'b0; #1;
      n_checks++;
      if ({busy, wen, wb_req, done} !== 4'b0000) begin n_fail++; $display("FAIL ten_idle: got %b required 0000", {busy, wen, wb_req, done}); end
      wb_gnt = 1'b0;
   endtask

   task automatic test_timeout();
      kick(); wb_gnt = 1'b1;
`ifdef RISCV_AES_TIMEOUT_EN
      for (int i = 1; i < 16; i++) begin
         next(); #1;
         n_checks++;
         if ({err, busy, wen} !== 3'b010) begin n_fail++; $display("FAIL to_wait%0d: got %b required 010", i, {err, busy, wen}); end
      end
      next(); #1;
      n_checks++;
      if ({err, busy, done, wen} !== 4'b1000) begin n_fail++; $display("FAIL to_fire: got %b required 1000", {err, busy, done, wen}); end
      kick(); #1;
      n_checks++;
      if ({err, busy} !== 2'b01) begin n_fail++; $display("FAIL to_clear: got %b required 01", {err, busy}); end
`else
      for (int i = 1; i < 40; i++) begin
         next(); #1;
         n_checks++;
         if ({err, busy, wen} !== 3'b010) begin n_fail++; $display("FAIL to_hold%0d: got %b required 010", i, {err, busy, wen}); end
      end
`endif
      wb_gnt = 1'b0;
      next(); test_en = 1'b1;
      next(); test_en = 1'b0; #1;
      n_checks++;
      if ({busy, err} !== 2'b00) begin n_fail++; $display("FAIL to_exit: got %b required 00", {busy, err}); end
   endtask

   initial begin
      test_reset();
      test_start();
      test_writeback();
      test_gnt_toggle();
      test_no_requeue();
      test_reset_mid();
      test_test_en();
      test_timeout();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
